// File: rtl/he_lut_engine.sv
// he_lut_engine
//   Histogram-equalisation table builder. One frame of pixels is accumulated
//   into a per-level histogram. The histogram is then walked once to form the
//   cumulative distribution and the equalised mapping lut[k]. The table is
//   streamed out, and the engine returns to IDLE ready for the next frame.
//
// Ports
//   clk               system clock, rising edge
//   reset             asynchronous reset, active low
//   start             frame-start request, honoured only in IDLE
//   in_valid/in_ready pixel stream handshake (in_ready high only in ACCUM)
//   pixel_value       input pixel
//   out_valid/out_ready table stream handshake
//   out_index         bin index of the presented entry
//   transformed_pixel equalised value lut[out_index]
//   out_last          marks the final entry (index LEVELS-1)
//   done              one-cycle pulse after the final table handshake
//   busy              high in every state except IDLE
module he_lut_engine #(
  parameter int PIX_W      = 8,
  parameter int NUM_PIXELS = 290400
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] pixel_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_index,
  output logic [PIX_W-1:0] transformed_pixel,
  output logic             out_last,
  output logic             done,
  output logic             busy
);

  localparam int LEVELS = 2 ** PIX_W;
  localparam int CNT_W  = $clog2(NUM_PIXELS + 1);
  localparam int PROD_W = CNT_W + PIX_W;

  localparam logic [CNT_W-1:0]  LAST_PIX = CNT_W'(NUM_PIXELS - 1);
  localparam logic [PIX_W-1:0]  LAST_BIN = PIX_W'(LEVELS - 1);
  localparam logic [PROD_W-1:0] SCALE    = PROD_W'(LEVELS - 1);
  localparam logic [PROD_W-1:0] DIVISOR  = PROD_W'(NUM_PIXELS);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_CDF, S_OUT} state_t;

  state_t state_reg, state_next;

  logic [CNT_W-1:0] hist_reg [LEVELS];
  logic [PIX_W-1:0] lut_reg  [LEVELS];
  logic [CNT_W-1:0] pix_cnt_reg;
  logic [CNT_W-1:0] cdf_reg;
  logic [PIX_W-1:0] bin_reg;
  logic             done_reg;

  logic              accept;
  logic              frame_full;
  logic              cdf_step;
  logic              cdf_last;
  logic              out_fire;
  logic              out_done;
  logic [CNT_W-1:0]  cdf_sum;
  logic [PROD_W-1:0] cdf_scaled;
  logic [PIX_W-1:0]  lut_value;

  assign accept     = (state_reg == S_ACCUM) && in_valid;
  assign frame_full = accept && (pix_cnt_reg == LAST_PIX);
  assign cdf_step   = (state_reg == S_CDF);
  assign cdf_last   = cdf_step && (bin_reg == LAST_BIN);
  assign out_fire   = (state_reg == S_OUT) && out_ready;
  assign out_done   = out_fire && (bin_reg == LAST_BIN);

  // Running CDF including the current bin. It never exceeds NUM_PIXELS, so
  // the scaled quotient always fits in PIX_W bits.
  assign cdf_sum    = cdf_reg + hist_reg[bin_reg];
  assign cdf_scaled = PROD_W'(cdf_sum) * SCALE;
  assign lut_value  = PIX_W'(cdf_scaled / DIVISOR);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and stream outputs
  always_comb begin
    state_next        = state_reg;
    in_ready          = 1'b0;
    out_valid         = 1'b0;
    out_last          = 1'b0;
    out_index         = '0;
    transformed_pixel = '0;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_ACCUM;
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        if (frame_full) state_next = S_CDF;
      end
      S_CDF: begin
        if (cdf_last) state_next = S_OUT;
      end
      S_OUT: begin
        out_valid         = 1'b1;
        out_index         = bin_reg;
        transformed_pixel = lut_reg[bin_reg];
        out_last          = (bin_reg == LAST_BIN);
        if (out_done) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state_reg != S_IDLE);
  assign done = done_reg;

  // Counters: pixel count, bin walker and CDF accumulator
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_cnt_reg <= '0;
      cdf_reg     <= '0;
      bin_reg     <= '0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= out_done;

      if ((state_reg == S_IDLE) && start) begin
        pix_cnt_reg <= '0;
      end else if (accept) begin
        pix_cnt_reg <= pix_cnt_reg + CNT_W'(1);
      end

      if (frame_full) begin
        bin_reg <= '0;
        cdf_reg <= '0;
      end else if (cdf_step) begin
        cdf_reg <= cdf_sum;
        bin_reg <= cdf_last ? '0 : bin_reg + PIX_W'(1);
      end else if (out_fire) begin
        // Wraps back to 0 after the last entry, ready for the next frame.
        bin_reg <= bin_reg + PIX_W'(1);
      end
    end
  end

  // Histogram and mapping table. Each bin is zeroed as the CDF pass reads
  // it, so the histogram is clean for the next frame without a clear phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LEVELS; i++) begin
        hist_reg[i] <= '0;
        lut_reg[i]  <= '0;
      end
    end else if (accept) begin
      hist_reg[pixel_value] <= hist_reg[pixel_value] + CNT_W'(1);
    end else if (cdf_step) begin
      hist_reg[bin_reg] <= '0;
      lut_reg[bin_reg]  <= lut_value;
    end
  end

endmodule

// File: tb/tb_he_lut_engine.sv
// tb_he_lut_engine
//   Directed bench for he_lut_engine with PIX_W=4, NUM_PIXELS=16. Frames are
//   fed through the input stream and the streamed table is compared entry by
//   entry against hand-computed tables (plus one small software reference
//   for a random frame).
module tb_he_lut_engine;

  localparam int PW = 4;
  localparam int NP = 16;
  localparam int LV = 16;

  typedef logic [PW-1:0] tab_t [LV];

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [PW-1:0] pixel_value = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_last;
  logic          done;
  logic          busy;
  logic [PW-1:0] out_index;
  logic [PW-1:0] transformed_pixel;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  he_lut_engine #(
    .PIX_W(PW),
    .NUM_PIXELS(NP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .pixel_value(pixel_value),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_index(out_index),
    .transformed_pixel(transformed_pixel),
    .out_last(out_last),
    .done(done),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a frame and push NP pixels; optional idle gaps on in_valid, with a
  // stray start pulse inside one gap.
  task automatic feed(input tab_t px, input bit gaps);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_accum", 32'(busy), 32'(1));
    check("done_clear", 32'(done), 32'(0));
    for (int i = 0; i < NP; i++) begin
      if (gaps && (i % 4 == 1)) begin
        in_valid = 1'b0;
        if (i == 5) start = 1'b1;
        tick();
        start = 1'b0;
        check("ready_accum", 32'(in_ready), 32'(1));
      end
      in_valid    = 1'b1;
      pixel_value = px[i];
      tick();
    end
    in_valid = 1'b0;
    check("ready_cdf", 32'(in_ready), 32'(0));
    check("busy_cdf", 32'(busy), 32'(1));
  endtask

  // Wait for the table and check every entry; optional 5-cycle stall at
  // index 4. Returns at the done cycle.
  task automatic drain(input string name, input tab_t exp, input bit stall, input bit measure);
    int n;
    n = 1;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check("out_valid_seen", 32'(out_valid), 32'(1));
    if (measure) check("latency", n, 17);
    for (int k = 0; k < LV; k++) begin
      out_ready = 1'b1;
      if (stall && k == 4) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          check("hold_idx", 32'(out_index), 32'(4));
          check("hold_data", 32'(transformed_pixel), 32'(exp[4]));
          check("hold_valid", 32'(out_valid), 32'(1));
        end
        out_ready = 1'b1;
      end
      check("valid", 32'(out_valid), 32'(1));
      check("index", 32'(out_index), k);
      check("last", 32'(out_last), 32'(k == LV - 1));
      check("lut", 32'(transformed_pixel), 32'(exp[k]));
      check("ready_out", 32'(in_ready), 32'(0));
      tick();
    end
    out_ready = 1'b0;
    check("done", 32'(done), 32'(1));
    check("busy_end", 32'(busy), 32'(0));
    check("valid_end", 32'(out_valid), 32'(0));
    $display("frame %s: table streamed, checks so far %0d", name, total);
  endtask

  tab_t px_zero, px_uni, px_split, px_rnd;
  tab_t t_zero, t_uni, t_split, t_rnd;
  int   h [LV];
  int   c;

  initial begin
    for (int i = 0; i < LV; i++) begin
      px_zero[i]  = '0;
      px_uni[i]   = PW'(i);
      px_split[i] = (i < 8) ? PW'(3) : PW'(12);
      t_zero[i]   = PW'(15);                       // cdf = 16 everywhere
      t_uni[i]    = PW'(i);                        // floor((k+1)*15/16) = k
      t_split[i]  = (i < 3) ? PW'(0) : (i < 12) ? PW'(7) : PW'(15);
    end

    // Reset state
    reset = 1'b0;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_last", 32'(out_last), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_index", 32'(out_index), 32'(0));
    check("rst_data", 32'(transformed_pixel), 32'(0));
    reset = 1'b1;
    tick();

    // Pixels offered in IDLE are refused
    in_valid    = 1'b1;
    pixel_value = PW'(5);
    tick();
    check("ready_idle", 32'(in_ready), 32'(0));
    check("busy_idle", 32'(busy), 32'(0));
    in_valid = 1'b0;
    tick();

    feed(px_zero, 1'b0);
    drain("all_zero", t_zero, 1'b0, 1'b1);
    tick();
    check("done_once", 32'(done), 32'(0));

    feed(px_uni, 1'b0);
    drain("uniform", t_uni, 1'b0, 1'b1);
    tick();

    feed(px_split, 1'b1);
    drain("split_stall", t_split, 1'b1, 1'b1);
    tick();

    // Back-to-back: frame B starts on frame A's done cycle
    feed(px_zero, 1'b0);
    drain("b2b_a", t_zero, 1'b0, 1'b0);
    feed(px_uni, 1'b0);
    drain("b2b_b", t_uni, 1'b0, 1'b1);
    tick();

    // Reset after 9 pixels, then a clean frame
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid    = 1'b1;
    pixel_value = PW'(3);
    for (int i = 0; i < 9; i++) tick();
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_ready", 32'(in_ready), 32'(0));
    check("mid_rst_valid", 32'(out_valid), 32'(0));
    check("mid_rst_done", 32'(done), 32'(0));
    tick();
    reset = 1'b1;
    tick();
    feed(px_uni, 1'b0);
    drain("after_reset", t_uni, 1'b0, 1'b1);
    tick();

    // Random frame against a software CDF reference
    for (int i = 0; i < LV; i++) h[i] = 0;
    for (int i = 0; i < NP; i++) begin
      px_rnd[i] = PW'($urandom_range(0, LV - 1));
      h[px_rnd[i]]++;
    end
    c = 0;
    for (int k = 0; k < LV; k++) begin
      c += h[k];
      t_rnd[k] = PW'((c * (LV - 1)) / NP);
    end
    feed(px_rnd, 1'b1);
    drain("random", t_rnd, 1'b0, 1'b1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
